// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and state encoding for the I2S stereo transmitter.
//   Default parameter values and the transmitter state enum.
package i2s_pkg;
    localparam int I2S_WIDTH_DEF        = 24;
    localparam int I2S_SLOT_BITS_DEF    = 32;
    localparam int I2S_SCLK_DIV_DEF     = 4;
    localparam int I2S_STARTUP_LOG2_DEF = 23;
    localparam int I2S_MUTE_FRAMES_DEF  = 10;

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_MUTE,
        ST_RUN
    } state_e;
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: sclk phase counter (d) and bit counter (b), registered sclk/lrclk.
//   clk, resetn   : clock, async active-low reset
//   i_en          : counters run when high, held at d=0/b=0 when low
//   o_sclk        : 1 when d >= SCLK_DIV/2
//   o_lrclk       : 1 when b >= SLOT_BITS (right slot)
//   o_tick        : this edge wraps d to 0 (sclk falling edge)
//   o_frame_end   : this edge is the last clk of the frame
//   o_b_next      : value b takes after this edge
module i2s_clkgen #(
    parameter  int SLOT_BITS = 32,
    parameter  int SCLK_DIV  = 4,
    localparam int BW        = $clog2(2 * SLOT_BITS),
    localparam int DW        = $clog2(SCLK_DIV)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_en,
    output logic          o_sclk,
    output logic          o_lrclk,
    output logic          o_tick,
    output logic          o_frame_end,
    output logic [BW-1:0] o_b_next
);
    logic [DW-1:0] d_q, d_d;
    logic [BW-1:0] b_q, b_d;
    logic          sclk_q, sclk_d;
    logic          lrclk_q, lrclk_d;
    logic          tick;

    always_comb begin
        d_d  = d_q;
        b_d  = b_q;
        tick = 1'b0;
        if (i_en) begin
            if (d_q == DW'(SCLK_DIV - 1)) begin
                tick = 1'b1;
                d_d  = '0;
                b_d  = (b_q == BW'(2 * SLOT_BITS - 1)) ? '0 : b_q + 1'b1;
            end else begin
                d_d = d_q + 1'b1;
            end
        end else begin
            d_d = '0;
            b_d = '0;
        end
        // Outputs are decoded from the next counter values so the flops
        // always agree with the counters they sit beside.
        sclk_d  = (d_d >= DW'(SCLK_DIV / 2));
        lrclk_d = (b_d >= BW'(SLOT_BITS));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_q     <= '0;
            b_q     <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            b_q     <= b_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign o_sclk      = sclk_q;
    assign o_lrclk     = lrclk_q;
    assign o_tick      = tick;
    assign o_frame_end = tick && (b_q == BW'(2 * SLOT_BITS - 1));
    assign o_b_next    = b_d;
endmodule

// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx: stereo I2S transmitter with startup delay, mute frames and
// a single-entry holding register.
//   clk, resetn            : master clock, async active-low reset
//   i_left/i_right/i_valid : stereo pair handshake input
//   o_ready                : holding register empty and running
//   o_mclk                 : clk pass-through
//   o_sclk/o_lrclk/o_sdin  : I2S serial outputs
//   o_underrun             : pulse when a frame starts without a fresh pair
//   o_running              : startup and mute frames complete
// Build option: define I2S_TX_LJ_MODE_EN for left-justified framing (MSB
// coincident with the lrclk edge); default is standard I2S (MSB one sclk late).
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int WIDTH        = I2S_WIDTH_DEF,
    parameter int SLOT_BITS    = I2S_SLOT_BITS_DEF,
    parameter int SCLK_DIV     = I2S_SCLK_DIV_DEF,
    parameter int STARTUP_LOG2 = I2S_STARTUP_LOG2_DEF,
    parameter int MUTE_FRAMES  = I2S_MUTE_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_mclk,
    output logic             o_sclk,
    output logic             o_lrclk,
    output logic             o_sdin,
    output logic             o_underrun,
    output logic             o_running
);
    localparam int BW = $clog2(2 * SLOT_BITS);

    state_e                  state_q, state_d;
    logic [STARTUP_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]              mute_q, mute_d;
    logic [WIDTH-1:0]        hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic                    hold_full_q, hold_full_d;
    logic [WIDTH-1:0]        left_q, left_d, right_q, right_d;
    logic                    sdin_q, sdin_d;
    logic                    ready_q, ready_d;
    logic                    underrun_q, underrun_d;
    logic                    running_q, running_d;

    logic                    tick, frame_end;
    logic [BW-1:0]           b_next;
    logic [WIDTH-1:0]        sample, shifted;
    int                      bn, pos;

    i2s_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .SCLK_DIV  (SCLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .resetn      (resetn),
        .i_en        (state_q != ST_STARTUP),
        .o_sclk      (o_sclk),
        .o_lrclk     (o_lrclk),
        .o_tick      (tick),
        .o_frame_end (frame_end),
        .o_b_next    (b_next)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mute_d      = mute_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        left_d      = left_q;
        right_d     = right_q;
        sdin_d      = sdin_q;
        underrun_d  = 1'b0;
        sample      = '0;
        shifted     = '0;
        bn          = 0;
        pos         = 0;

        case (state_q)
            ST_STARTUP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = (MUTE_FRAMES == 0) ? ST_RUN : ST_MUTE;
            end
            ST_MUTE: begin
                if (frame_end) begin
                    if (mute_q == 8'(MUTE_FRAMES - 1)) state_d = ST_RUN;
                    else                               mute_d  = mute_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (frame_end) begin
            if (hold_full_q) begin
                left_d      = hold_l_q;
                right_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                left_d  = '0;
                right_d = '0;
                if (state_q == ST_RUN) underrun_d = 1'b1;
            end
        end

        // A capture on the frame-load edge lands after the move above, so
        // it waits for the following frame.
        if (i_valid && ready_q) begin
            hold_l_d    = i_left;
            hold_r_d    = i_right;
            hold_full_d = 1'b1;
        end

        // Serial bit for the slot position entered on this sclk falling edge,
        // taken from the post-load shifters so slot bit 0 sees the new word.
        if (tick) begin
            bn     = int'(b_next);
            sample = (bn >= SLOT_BITS) ? right_d : left_d;
            pos    = (bn >= SLOT_BITS) ? bn - SLOT_BITS : bn;
`ifdef I2S_TX_LJ_MODE_EN
            if (pos < WIDTH) begin
                shifted = sample >> (WIDTH - 1 - pos);
                sdin_d  = shifted[0];
            end else begin
                sdin_d = 1'b0;
            end
`else
            if (pos >= 1 && pos <= WIDTH) begin
                shifted = sample >> (WIDTH - pos);
                sdin_d  = shifted[0];
            end else begin
                sdin_d = 1'b0;
            end
`endif
        end

        running_d = (state_d == ST_RUN);
        ready_d   = running_d && !hold_full_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_STARTUP;
            cnt_q       <= '0;
            mute_q      <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            sdin_q      <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mute_q      <= mute_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            left_q      <= left_d;
            right_q     <= right_d;
            sdin_q      <= sdin_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
            running_q   <= running_d;
        end
    end

    assign o_mclk     = clk;
    assign o_sdin     = sdin_q;
    assign o_ready    = ready_q;
    assign o_underrun = underrun_q;
    assign o_running  = running_q;
endmodule

// File: doc/i2s_stereo_tx.md
I2S_STEREO_TX -- requirements
Module: i2s_stereo_tx

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits per channel (1..32).
REQ-002 Parameter SLOT_BITS, default 32, sclk periods per channel slot (WIDTH+1..64).
REQ-003 Parameter SCLK_DIV, default 4, mclk cycles per sclk period (even, >=2).
REQ-004 Parameter STARTUP_LOG2, default 23, startup delay is 2^STARTUP_LOG2 clk cycles.
REQ-005 Parameter MUTE_FRAMES, default 10, zero-data frames sent after startup (0..255).
REQ-006 clk  input  1  master clock; one clock domain only.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 i_left  input  WIDTH  left sample, two's complement.
REQ-009 i_right  input  WIDTH  right sample, two's complement.
REQ-010 i_valid  input  1  stereo pair on i_left/i_right is valid.
REQ-011 o_ready  output  1  holding register can accept a pair this cycle.
REQ-012 o_mclk  output  1  equals clk, combinational pass-through.
REQ-013 o_sclk  output  1  serial bit clock.
REQ-014 o_lrclk  output  1  word select: 0 = left slot, 1 = right slot.
REQ-015 o_sdin  output  1  serial data, MSB first.
REQ-016 o_underrun  output  1  one-cycle pulse when a frame is sent without a fresh pair.
REQ-017 o_running  output  1  high once startup delay and mute frames are complete.

Function
REQ-018 Phase counter d SHALL count 0..SCLK_DIV-1 per clk; o_sclk SHALL be 1 when d >= SCLK_DIV/2.
REQ-019 Bit counter b SHALL count 0..2*SLOT_BITS-1, advancing when d wraps; o_lrclk SHALL be 1 when b >= SLOT_BITS.
REQ-020 Frame period SHALL be 2*SLOT_BITS*SCLK_DIV clk cycles (256 at defaults).
REQ-021 o_sdin SHALL change only on the clk edge where d wraps to 0, which is the sclk falling edge; it is stable across the sclk rising edge.
REQ-022 I2S format: the MSB of each channel SHALL appear at slot bit 1, one sclk after the lrclk edge; bits after the LSB SHALL be 0.
REQ-023 Transfer: a pair SHALL be captured when i_valid and o_ready are both 1 on a clk edge.
REQ-024 o_ready SHALL be 1 when o_running is 1 and the single-entry holding register is empty.
REQ-025 At the last clk of each frame (b = 2*SLOT_BITS-1, d = SCLK_DIV-1), a full holding register SHALL move to the left/right shifters and be marked empty.
REQ-026 If the holding register is empty at that edge while o_running is 1, the shifters SHALL load zeros and o_underrun SHALL pulse high for that cycle.
REQ-027 A capture on that same frame-load edge SHALL fill the holding register for the next frame; that frame still underruns.
REQ-028 Startup: o_sclk, o_lrclk and o_sdin SHALL be held 0 until 2^STARTUP_LOG2 cycles have elapsed after reset release; o_mclk SHALL run throughout.
REQ-029 After startup, o_sclk and o_lrclk SHALL start at b = 0, d = 0; MUTE_FRAMES frames of zero data SHALL follow with o_ready low and no underrun pulses.
REQ-030 o_running SHALL rise at the first frame-load edge after the mute frames complete.
REQ-031 All outputs except o_mclk SHALL be registered.

Reset
REQ-032 resetn low SHALL immediately clear d, b, the startup and mute counters, the shifters and the holding register.
REQ-033 During reset, o_sclk, o_lrclk, o_sdin, o_ready, o_underrun and o_running SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL discard any held pair; after release the full startup sequence SHALL repeat.

Configuration
REQ-035 When I2S_TX_LJ_MODE_EN is defined, the format SHALL be left-justified: MSB at slot bit 0, coincident with the lrclk edge, and WIDTH up to SLOT_BITS is allowed.
REQ-036 When I2S_TX_LJ_MODE_EN is not defined, the format SHALL be standard I2S per REQ-022.

Structure
REQ-037 Package i2s_pkg SHALL hold the default parameter constants and the state enum {ST_STARTUP, ST_MUTE, ST_RUN}.
REQ-038 Sub-module i2s_clkgen SHALL own d, b and the generation of o_sclk and o_lrclk; the parent SHALL own the handshake, holding register, shifters and state machine.
REQ-039 State transitions SHALL be STARTUP->MUTE when the startup count is done, MUTE->RUN at the frame-load edge after MUTE_FRAMES frames, and any state->STARTUP on reset.

Verification
REQ-040 STARTUP_LOG2=4, MUTE_FRAMES=2: o_sclk, o_lrclk and o_sdin stay 0 for 16 cycles; o_running rises 2 frames (512 cycles) later; no o_underrun pulse before then.
REQ-041 Defaults, pair L=24'hA5F00F, R=24'h000001: o_sdin shows L MSB-first starting at left slot bit 1, then 7 zeros; R has its LSB (1) at right slot bit 24.
REQ-042 Defaults, i_valid held 0 after running: o_sdin is all 0 and o_underrun pulses once every 256 cycles.
REQ-043 i_valid asserted on the frame-load edge: that frame is zeros plus one o_underrun pulse; the next frame carries the pair.
REQ-044 resetn pulsed low mid-right-slot: outputs go 0 immediately; the held pair never appears; startup repeats.
REQ-045 With I2S_TX_LJ_MODE_EN defined, WIDTH=32, SLOT_BITS=32, L=32'h80000000: o_sdin is 1 during the first sclk after o_lrclk falls.
